multihot_serializer: RTL and testbench

Serializes a multi-hot request vector into a stream of binary indices, one set bit per handshake, lowest index first. Sits directly upstream of `binary_to_onehot`: each emitted index drives that decoder, so an N-hot vector is replayed as N one-hot strobes. Used wherever a batch of pending events must be serviced one at a time, such as interrupt or flush requests.

---
 rtl/multihot_serializer.sv | 93 +++++++++
 tb/tb_multihot_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multihot_serializer.sv
// Replays a multi-hot request vector as a stream of binary indices, lowest set bit first.
// Build option MULTIHOT_SERIALIZER_LAST_EN adds the output_last port.
//
//   state     | meaning
//   ----------+--------------------------------------------
//   IDLE      | no pending bits, waiting for a vector
//   SERIALIZE | pending register holds at least one set bit

module multihot_serializer #(
   parameter int WIDTH_ONEHOT = 8,
   parameter int WIDTH_BINARY = $clog2(WIDTH_ONEHOT)
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [WIDTH_ONEHOT-1:0] input_vector,
   input  logic                    input_valid,
   output logic                    input_ready,
   output logic [WIDTH_BINARY-1:0] output_index,
   output logic                    output_valid,
   input  logic                    output_ready,
`ifdef MULTIHOT_SERIALIZER_LAST_EN
   output logic                    output_last,
`endif
   output logic                    busy
);

   typedef enum logic {IDLE, SERIALIZE} state_t;

   localparam logic [WIDTH_ONEHOT-1:0] ONE = WIDTH_ONEHOT'(1);

   state_t                  state_q, state_d;
   logic [WIDTH_ONEHOT-1:0] pending_q, pending_d;
   logic [WIDTH_BINARY-1:0] index_q, index_d;
   logic                    valid_q, valid_d;
   logic                    one_left;
   logic                    out_hs;
   logic                    in_hs;
`ifdef MULTIHOT_SERIALIZER_LAST_EN
   logic                    last_q, last_d;
`endif

   // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
   assign one_left    = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);
   assign input_ready = (state_q == IDLE) || (one_left && output_ready);
   assign out_hs      = valid_q && output_ready;
   assign in_hs       = input_valid && input_ready;

   always_comb begin
      pending_d = pending_q;
      if (out_hs) pending_d = pending_q & (pending_q - ONE);
      // A refill in SERIALIZE only happens as the last bit leaves, so overwriting is safe.
      if (in_hs) pending_d = input_vector;

      state_d = (pending_d != '0) ? SERIALIZE : IDLE;
      valid_d = (pending_d != '0);

      index_d = '0;
      for (int i = WIDTH_ONEHOT - 1; i >= 0; i--) begin
         if (pending_d[i]) index_d = i[WIDTH_BINARY-1:0];
      end
`ifdef MULTIHOT_SERIALIZER_LAST_EN
      last_d = valid_d && ((pending_d & (pending_d - ONE)) == '0);
`endif
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         pending_q <= '0;
         index_q   <= '0;
         valid_q   <= 1'b0;
`ifdef MULTIHOT_SERIALIZER_LAST_EN
         last_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         index_q   <= index_d;
         valid_q   <= valid_d;
`ifdef MULTIHOT_SERIALIZER_LAST_EN
         last_q    <= last_d;
`endif
      end
   end

   assign output_index = index_q;
   assign output_valid = valid_q;
   assign busy         = (state_q == SERIALIZE);
`ifdef MULTIHOT_SERIALIZER_LAST_EN
   assign output_last  = last_q;
`endif

endmodule

// File: tb/tb_multihot_serializer.sv
// Scoreboard bench for multihot_serializer: accepted vectors expand into expected indices,
// popped and compared on each output handshake.

module tb_multihot_serializer;

   localparam int W  = 8;
   localparam int WB = 3;

   logic          clock  = 1'b0;
   logic          resetn = 1'b1;
   logic [W-1:0]  input_vector;
   logic          input_valid;
   logic          input_ready;
   logic [WB-1:0] output_index;
   logic          output_valid;
   logic          output_ready;
   logic          busy;
`ifdef MULTIHOT_SERIALIZER_LAST_EN
   logic          output_last;
`endif

   int            checks = 0;
   int            errors = 0;
   int            pop_cnt = 0;
   int            pc0;
   logic [WB-1:0] exp_q[$];
   logic          prev_stall = 1'b0;
   logic [WB-1:0] prev_idx = '0;

   multihot_serializer #(.WIDTH_ONEHOT(W), .WIDTH_BINARY(WB)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .input_vector (input_vector),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .output_index (output_index),
      .output_valid (output_valid),
      .output_ready (output_ready),
`ifdef MULTIHOT_SERIALIZER_LAST_EN
      .output_last  (output_last),
`endif
      .busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor, sampled mid-cycle where both handshakes are settled.
   always @(negedge clock) begin
      if (resetn) begin
         if (prev_stall) begin
            check_val("hold_valid", 32'(output_valid), 32'd1);
            check_val("hold_idx", 32'(output_index), 32'(prev_idx));
         end
         if (input_valid && input_ready)
            for (int i = 0; i < W; i++)
               if (input_vector[i]) exp_q.push_back(i[WB-1:0]);
         if (output_valid && output_ready) begin
            pop_cnt++;
            check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_val("sb_idx", 32'(output_index), 32'(exp_q.pop_front()));
         end
         prev_stall = output_valid && !output_ready;
         prev_idx   = output_index;
      end
   end

   task automatic expect_cycle(input string tag, input logic v, input logic [WB-1:0] idx,
                               input logic last, input logic rdy);
      @(negedge clock);
      check_val({tag, "_valid"}, 32'(output_valid), 32'(v));
      check_val({tag, "_busy"}, 32'(busy), 32'(v));
      check_val({tag, "_rdy"}, 32'(input_ready), 32'(rdy));
      if (v) check_val({tag, "_idx"}, 32'(output_index), 32'(idx));
`ifdef MULTIHOT_SERIALIZER_LAST_EN
      check_val({tag, "_last"}, 32'(output_last), 32'(last));
`else
      if (last) ;
`endif
      @(posedge clock); #1;
   endtask

   task automatic accept(input logic [W-1:0] vec);
      input_vector = vec;
      input_valid  = 1'b1;
      @(posedge clock); #1;
      input_valid  = 1'b0;
   endtask

   initial begin
      input_vector = '0;
      input_valid  = 1'b0;
      output_ready = 1'b1;
      resetn       = 1'b0;
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;

      @(negedge clock);
      check_val("rst_valid", 32'(output_valid), 32'd0);
      check_val("rst_idx", 32'(output_index), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_rdy", 32'(input_ready), 32'd1);
`ifdef MULTIHOT_SERIALIZER_LAST_EN
      check_val("rst_last", 32'(output_last), 32'd0);
`endif
      @(posedge clock); #1;

      // 8'b1010_0100 -> 2, 5, 7 back to back
      accept(8'hA4);
      expect_cycle("t1a", 1, 3'd2, 0, 0);
      expect_cycle("t1b", 1, 3'd5, 0, 0);
      expect_cycle("t1c", 1, 3'd7, 1, 1);
      expect_cycle("t1d", 0, 3'd0, 0, 1);

      // all-zero vector is swallowed
      accept(8'h00);
      repeat (3) expect_cycle("t2", 0, 3'd0, 0, 1);

      // stall for four cycles on index 0
      output_ready = 1'b0;
      accept(8'h81);
      repeat (4) expect_cycle("t3s", 1, 3'd0, 0, 0);
      output_ready = 1'b1;
      expect_cycle("t3a", 1, 3'd0, 0, 0);
      expect_cycle("t3b", 1, 3'd7, 1, 1);
      expect_cycle("t3c", 0, 3'd0, 0, 1);

      // back-to-back refill on the final index cycle
      input_vector = 8'h80;
      input_valid  = 1'b1;
      @(posedge clock); #1;
      input_vector = 8'h03;
      expect_cycle("t4a", 1, 3'd7, 1, 1);
      input_valid  = 1'b0;
      expect_cycle("t4b", 1, 3'd0, 0, 0);
      expect_cycle("t4c", 1, 3'd1, 1, 1);
      expect_cycle("t4d", 0, 3'd0, 0, 1);

      // reset after three indices of 8'hFF
      accept(8'hFF);
      expect_cycle("t5a", 1, 3'd0, 0, 0);
      expect_cycle("t5b", 1, 3'd1, 0, 0);
      expect_cycle("t5c", 1, 3'd2, 0, 0);
      resetn = 1'b0;
      #1;
      check_val("t5_rst_valid", 32'(output_valid), 32'd0);
      check_val("t5_rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      prev_stall = 1'b0;
      @(posedge clock); #1;
      resetn = 1'b1;
      repeat (5) expect_cycle("t5idle", 0, 3'd0, 0, 1);

      // 8'hFF with output_ready toggling every cycle
      output_ready = 1'b0;
      accept(8'hFF);
      pc0 = pop_cnt;
      repeat (16) begin
         output_ready = ~output_ready;
         @(posedge clock); #1;
      end
      @(negedge clock);
      check_val("t6_pops", 32'(pop_cnt - pc0), 32'd8);
      check_val("t6_busy", 32'(busy), 32'd0);
      check_val("t6_valid", 32'(output_valid), 32'd0);
      check_val("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
